seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_pat_dec.sv | 37 +++
 rtl/seg7_reader.sv | 219 +++++++++++++++++++++
 tb/tb_seg7_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display reader.
// Holds the active-low segment patterns for BCD digits 0..9, the all-off
// pattern and its code, and the capture FSM state type.
// Optional build macro: SEG7_READER_BLANK_EN (consumed by seg7_pat_dec).
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold
    } state_e;

endpackage

// File: rtl/seg7_pat_dec.sv
// Combinational segment-pattern decoder.
// Ports:
//   seg_n  - active-low segment lines {g,f,e,d,c,b,a}
//   dec_ok - high when seg_n is a recognised pattern
//   bcd    - decoded value (0 when dec_ok is low)
// Build macro SEG7_READER_BLANK_EN: when defined, the all-off pattern decodes
// to BLANK_CODE; otherwise it is treated as undecodable.
module seg7_pat_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       dec_ok,
    output logic [3:0] bcd
);

    always_comb begin
        dec_ok = 1'b1;
        bcd    = 4'h0;
        case (seg_n)
            PAT_0:     bcd = 4'd0;
            PAT_1:     bcd = 4'd1;
            PAT_2:     bcd = 4'd2;
            PAT_3:     bcd = 4'd3;
            PAT_4:     bcd = 4'd4;
            PAT_5:     bcd = 4'd5;
            PAT_6:     bcd = 4'd6;
            PAT_7:     bcd = 4'd7;
            PAT_8:     bcd = 4'd8;
            PAT_9:     bcd = 4'd9;
`ifdef SEG7_READER_BLANK_EN
            PAT_BLANK: bcd = BLANK_CODE;
`endif
            default:   dec_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Recovers BCD digits from a multiplexed, active-low seven-segment display bus.
// Each digit strobe window is debounced, sampled at most once, and a digit's
// output only changes after CONFIRM consecutive identical samples.
// Parameters: N_DIG (1..8), STABLE_CYC (1..255), CONFIRM (1..15).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   seg_n     - active-low segment lines {g,f,e,d,c,b,a}
//   dig_en_n  - active-low digit strobes, one low at a time
//   digits    - recovered BCD, digit i at [4i+3:4i]
//   valid     - every digit confirmed at least once since reset
//   upd       - one-cycle pulse when a digit field changes value
//   err       - one-cycle pulse when an undecodable pattern is sampled
//   err_cnt   - saturating count of err pulses
// Build macro SEG7_READER_BLANK_EN: all-off pattern decodes as 4'hF.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG      = 4,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CONFIRM    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_n,
    input  logic [N_DIG-1:0]     dig_en_n,
    output logic [4*N_DIG-1:0]   digits,
    output logic                 valid,
    output logic                 upd,
    output logic                 err,
    output logic [7:0]           err_cnt
);

    // Input register stage and its one-cycle-delayed copy for change detection
    logic [6:0]       seg_q, seg_p;
    logic [N_DIG-1:0] dig_q, dig_p;

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // Sample latched at the end of SETTLE, consumed in CAPTURE
    logic [6:0]       cap_seg_q, cap_seg_d;
    logic [N_DIG-1:0] cap_sel_q, cap_sel_d;

    logic [N_DIG-1:0][3:0] cand_q, cand_d;
    logic [N_DIG-1:0][3:0] match_q, match_d;

    // Confirmed value waiting to be written into digits on the next cycle
    logic             commit_q, commit_d;
    logic [N_DIG-1:0] commit_sel_q, commit_sel_d;
    logic [3:0]       commit_val_q, commit_val_d;

    logic [N_DIG-1:0][3:0] digits_q, digits_d;
    logic [N_DIG-1:0]      confirmed_q, confirmed_d;
    logic                  upd_q, upd_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [N_DIG-1:0] sel;
    logic             one_hot;
    logic             changed;
    logic             dig_changed;
    logic             dec_ok;
    logic [3:0]       dec_bcd;

    assign sel         = ~dig_q;
    assign one_hot     = $onehot(sel);
    assign changed     = ({seg_q, dig_q} != {seg_p, dig_p});
    assign dig_changed = (dig_q != dig_p);

    seg7_pat_dec u_dec (
        .seg_n  (cap_seg_q),
        .dec_ok (dec_ok),
        .bcd    (dec_bcd)
    );

    // Window FSM and per-digit confirmation bookkeeping
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_seg_d    = cap_seg_q;
        cap_sel_d    = cap_sel_q;
        cand_d       = cand_q;
        match_d      = match_q;
        commit_d     = 1'b0;
        commit_sel_d = commit_sel_q;
        commit_val_d = commit_val_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            StIdle: begin
                if (one_hot) begin
                    state_d = StSettle;
                    cnt_d   = 8'd1;
                end
            end
            StSettle: begin
                if (!one_hot) begin
                    state_d = StIdle;
                end else if (changed) begin
                    cnt_d = 8'd1;
                end else if (cnt_q == 8'(STABLE_CYC)) begin
                    state_d   = StCapture;
                    cap_seg_d = seg_q;
                    cap_sel_d = sel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StCapture: begin
                state_d = StHold;
                if (dec_ok) begin
                    for (int i = 0; i < N_DIG; i++) begin
                        if (cap_sel_q[i]) begin
                            if (cand_q[i] == dec_bcd) begin
                                if (match_q[i] < 4'(CONFIRM)) begin
                                    match_d[i] = match_q[i] + 4'd1;
                                end
                            end else begin
                                cand_d[i]  = dec_bcd;
                                match_d[i] = 4'd1;
                            end
                            // Re-commits at saturation are harmless: upd needs a change
                            if (match_d[i] == 4'(CONFIRM)) begin
                                commit_d     = 1'b1;
                                commit_sel_d = cap_sel_q;
                                commit_val_d = dec_bcd;
                            end
                        end
                    end
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    for (int i = 0; i < N_DIG; i++) begin
                        if (cap_sel_q[i]) begin
                            match_d[i] = 4'd0;
                        end
                    end
                end
            end
            StHold: begin
                // Only a strobe change ends the window; segment changes are ignored
                if (dig_changed) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output stage: apply a pending confirmation one cycle after CAPTURE
    always_comb begin
        digits_d    = digits_q;
        confirmed_d = confirmed_q;
        upd_d       = 1'b0;
        if (commit_q) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (commit_sel_q[i]) begin
                    digits_d[i]    = commit_val_q;
                    confirmed_d[i] = 1'b1;
                    if (digits_q[i] != commit_val_q) begin
                        upd_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= '1;
            seg_p        <= '1;
            dig_q        <= '1;
            dig_p        <= '1;
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            cap_seg_q    <= '1;
            cap_sel_q    <= '0;
            cand_q       <= '0;
            match_q      <= '0;
            commit_q     <= 1'b0;
            commit_sel_q <= '0;
            commit_val_q <= 4'h0;
            digits_q     <= '0;
            confirmed_q  <= '0;
            upd_q        <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            seg_q        <= seg_n;
            seg_p        <= seg_q;
            dig_q        <= dig_en_n;
            dig_p        <= dig_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_seg_q    <= cap_seg_d;
            cap_sel_q    <= cap_sel_d;
            cand_q       <= cand_d;
            match_q      <= match_d;
            commit_q     <= commit_d;
            commit_sel_q <= commit_sel_d;
            commit_val_q <= commit_val_d;
            digits_q     <= digits_d;
            confirmed_q  <= confirmed_d;
            upd_q        <= upd_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign digits  = digits_q;
    assign valid   = &confirmed_q;
    assign upd     = upd_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader with default parameters. Strobe windows are issued by a
// stimulus process that also updates a reference model and queues every
// expected upd/err pulse; a monitor pops and checks one entry per pulse.
module tb_seg7_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam int CONF   = 2;
    localparam int GAP    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   dig_en_n;
    logic [4*NDIG-1:0] digits;
    logic              valid;
    logic              upd;
    logic              err;
    logic [7:0]        err_cnt;

    seg7_reader #(
        .N_DIG      (NDIG),
        .STABLE_CYC (STABLE),
        .CONFIRM    (CONF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_n    (seg_n),
        .dig_en_n (dig_en_n),
        .digits   (digits),
        .valid    (valid),
        .upd      (upd),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] dig;
        bit          vld;
        logic [7:0]  ec;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state
    logic [3:0] m_dig   [NDIG];
    logic [3:0] m_cand  [NDIG];
    int         m_match [NDIG];
    bit         m_conf  [NDIG];
    int         m_errcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] m_packed();
        logic [15:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    function automatic bit m_valid();
        bit v = 1'b1;
        for (int i = 0; i < NDIG; i++) v &= m_conf[i];
        return v;
    endfunction

    function automatic bit model_dec(input logic [6:0] p, output logic [3:0] v);
        v = 4'h0;
        for (int i = 0; i < 10; i++) begin
            if (p == pat_tab[i]) begin
                v = 4'(i);
                return 1'b1;
            end
        end
`ifdef SEG7_READER_BLANK_EN
        if (p == 7'h7F) begin
            v = 4'hF;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) begin
            m_dig[i]   = 4'h0;
            m_cand[i]  = 4'h0;
            m_match[i] = 0;
            m_conf[i]  = 1'b0;
        end
        m_errcnt = 0;
    endtask

    // A steady window longer than STABLE cycles yields exactly one sample
    task automatic model_sample(input int d, input logic [6:0] pat, input int len);
        logic [3:0] v;
        ev_t        e;
        if (len <= STABLE) return;
        if (model_dec(pat, v)) begin
            if (m_cand[d] == v) begin
                if (m_match[d] < CONF) m_match[d]++;
            end else begin
                m_cand[d]  = v;
                m_match[d] = 1;
            end
            if (m_match[d] == CONF) begin
                m_conf[d] = 1'b1;
                if (m_dig[d] != v) begin
                    m_dig[d] = v;
                    e.is_err = 1'b0;
                    e.dig    = m_packed();
                    e.vld    = m_valid();
                    e.ec     = 8'(m_errcnt);
                    exp_q.push_back(e);
                end
            end
        end else begin
            m_match[d] = 0;
            if (m_errcnt < 255) m_errcnt++;
            e.is_err = 1'b1;
            e.dig    = m_packed();
            e.vld    = m_valid();
            e.ec     = 8'(m_errcnt);
            exp_q.push_back(e);
        end
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dig_en_n = '1;
            seg_n    = 7'h7F;
        end
    endtask

    task automatic window(input int d, input logic [6:0] pat, input int len);
        model_sample(d, pat, len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            dig_en_n = ~(4'b0001 << d);
            seg_n    = pat;
        end
        gap(GAP);
    endtask

    task automatic check_state(input string name);
        chk({name, "_digits"}, 32'(digits), 32'(m_packed()));
        chk({name, "_valid"}, 32'(valid), 32'(m_valid()));
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'(m_errcnt));
    endtask

    task automatic mon_event(input bit is_err);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got %s pulse expected none", is_err ? "err" : "upd");
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind_is_err", 32'(is_err), 32'(e.is_err));
            chk("evt_digits", 32'(digits), 32'(e.dig));
            chk("evt_valid", 32'(valid), 32'(e.vld));
            chk("evt_err_cnt", 32'(err_cnt), 32'(e.ec));
        end
    endtask

    always @(negedge clk) begin
        if (upd === 1'b1) mon_event(1'b0);
        if (err === 1'b1) mon_event(1'b1);
    end

    initial begin
        int         lens [5] = '{3, 4, 6, 7, 8};
        int         d;
        int         len;
        logic [6:0] pat;

        rst      = 1'b1;
        seg_n    = 7'h7F;
        dig_en_n = '1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        gap(2);

        // Digit 0 shows "3" for two 6-cycle windows
        window(0, 7'h30, 6);
        window(0, 7'h30, 6);
        chk("d0_is_3", 32'(digits[3:0]), 32'h3);

        // Scan 1,2,3,4 across all digits twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NDIG; i++) window(i, pat_tab[i + 1], 6);
        end
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_valid", 32'(valid), 32'h1);
        chk("scan_err_cnt", 32'(err_cnt), 32'h0);

        // All-off pattern on digit 2
        window(2, 7'h7F, 6);
        window(2, 7'h7F, 6);
        check_state("blank");

        // Segments toggling every 2 cycles inside a 10-cycle strobe
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dig_en_n = 4'b1101;
            seg_n    = ((k / 2) % 2 == 1) ? 7'h12 : 7'h30;
        end
        gap(GAP);
        check_state("toggle");

        // Two strobes low at once for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            dig_en_n = 4'b1100;
            seg_n    = 7'h10;
        end
        gap(GAP);
        check_state("two_low");

        // Strobe too short to reach the stability count
        window(3, 7'h02, 4);
        window(3, 7'h02, 3);
        check_state("short");

        // Reset landing on the CAPTURE cycle of a confirming window
        window(0, 7'h78, 6);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            dig_en_n = 4'b1110;
            seg_n    = 7'h78;
        end
        @(negedge clk);
        dig_en_n = '1;
        seg_n    = 7'h7F;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_digits", 32'(digits), 32'h0);
        chk("midrst_valid", 32'(valid), 32'h0);
        chk("midrst_upd", 32'(upd), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'h0);
        chk("midrst_queue_empty", 32'(exp_q.size()), 32'h0);
        model_reset();
        gap(GAP);
        // Candidates were cleared, so one window alone must not confirm
        window(0, 7'h78, 6);
        check_state("post_rst");

        // Randomized windows
        for (int n = 0; n < 80; n++) begin
            d   = int'($urandom_range(0, NDIG - 1));
            len = lens[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) < 8) pat = pat_tab[$urandom_range(0, 9)];
            else pat = 7'($urandom);
            window(d, pat, len);
        end

        gap(10);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
